// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: turns SLC-3 Mem_OE/Mem_WE level strobes into timed external SRAM cycles
module sram_access_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] MAR,
    input  logic [DATA_W-1:0] Data_to_SRAM,
    output logic [DATA_W-1:0] Data_from_SRAM,
    output logic              Mem_Ready,
    output logic              Busy,
    output logic              Bus_err,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    input  logic [DATA_W-1:0] SRAM_DQ_in,
    output logic [DATA_W-1:0] SRAM_DQ_out,
    output logic              SRAM_DQ_oe
);
    localparam int MAX_W = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] READ        = 3'd1;
    localparam logic [2:0] WRITE_PULSE = 3'd2;
    localparam logic [2:0] WRITE_HOLD  = 3'd3;
    localparam logic [2:0] RECOVER     = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] wr_data;
    logic              rd_last;

    // access sequencer: accepts one request from IDLE, times the strobe window, then waits out the held strobe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            rd_data <= '0;
            wr_data <= '0;
            Bus_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!Mem_WE) begin
                        addr_q  <= MAR;
                        wr_data <= Data_to_SRAM;
                        cnt     <= WR_LOAD;
                        Bus_err <= Bus_err | ~Mem_OE;
                        state   <= WRITE_PULSE;
                    end else if (!Mem_OE) begin
                        addr_q <= MAR;
                        cnt    <= RD_LOAD;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rd_data <= SRAM_DQ_in;
                        state   <= Mem_OE ? IDLE : RECOVER;
                    end
                end
                WRITE_PULSE: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else state <= WRITE_HOLD;
                end
                WRITE_HOLD: state <= Mem_WE ? IDLE : RECOVER;
                RECOVER: if (Mem_OE && Mem_WE) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM strobes and handshake decoded from state; read data bypasses straight through on the last READ cycle
    always_comb begin
        rd_last        = (state == READ) && (cnt == '0);
        SRAM_CE_N      = !((state == READ) || (state == WRITE_PULSE) || (state == WRITE_HOLD));
        SRAM_OE_N      = state != READ;
        SRAM_WE_N      = state != WRITE_PULSE;
        SRAM_UB_N      = 1'b0;
        SRAM_LB_N      = 1'b0;
        SRAM_DQ_oe     = (state == WRITE_PULSE) || (state == WRITE_HOLD);
        SRAM_DQ_out    = wr_data;
        SRAM_ADDR      = addr_q;
        Busy           = state != IDLE;
        Mem_Ready      = !Reset && (rd_last || (state == WRITE_HOLD));
        Data_from_SRAM = rd_last ? SRAM_DQ_in : rd_data;
    end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: table-driven check of default timing plus hand sequences for slow wait states
module tb_sram_access_ctrl;
    typedef struct {
        logic [1:0]  in;
        logic [19:0] mar;
        logic [15:0] wd;
        logic [6:0]  flg;
        logic [19:0] addr;
        logic [15:0] dout;
        logic [15:0] dqo;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, oe = 1'b1, we = 1'b1;
    logic [19:0] mar = '0;
    logic [15:0] wd = '0;
    int tests = 0, fails = 0;

    logic [15:0] dout_d, dqi_d, dqo_d, dout_s, dqi_s, dqo_s;
    logic [19:0] addr_d, addr_s;
    logic rdy_d, busy_d, berr_d, ce_d, oen_d, wen_d, ub_d, lb_d, dqoe_d;
    logic rdy_s, busy_s, berr_s, ce_s, oen_s, wen_s, ub_s, lb_s, dqoe_s;
    logic [15:0] mem_d [256];
    logic [15:0] mem_s [256];

    always #5 clk = ~clk;

    sram_access_ctrl u_def (
        .Clk(clk), .Reset(rst), .Mem_OE(oe), .Mem_WE(we), .MAR(mar), .Data_to_SRAM(wd),
        .Data_from_SRAM(dout_d), .Mem_Ready(rdy_d), .Busy(busy_d), .Bus_err(berr_d),
        .SRAM_ADDR(addr_d), .SRAM_CE_N(ce_d), .SRAM_OE_N(oen_d), .SRAM_WE_N(wen_d),
        .SRAM_UB_N(ub_d), .SRAM_LB_N(lb_d), .SRAM_DQ_in(dqi_d), .SRAM_DQ_out(dqo_d),
        .SRAM_DQ_oe(dqoe_d)
    );

    sram_access_ctrl #(.READ_WAIT(3), .WRITE_WAIT(4)) u_slow (
        .Clk(clk), .Reset(rst), .Mem_OE(oe), .Mem_WE(we), .MAR(mar), .Data_to_SRAM(wd),
        .Data_from_SRAM(dout_s), .Mem_Ready(rdy_s), .Busy(busy_s), .Bus_err(berr_s),
        .SRAM_ADDR(addr_s), .SRAM_CE_N(ce_s), .SRAM_OE_N(oen_s), .SRAM_WE_N(wen_s),
        .SRAM_UB_N(ub_s), .SRAM_LB_N(lb_s), .SRAM_DQ_in(dqi_s), .SRAM_DQ_out(dqo_s),
        .SRAM_DQ_oe(dqoe_s)
    );

    // asynchronous SRAM models: write on the edge while CE/WE low, read data only while CE/OE low
    always @(posedge clk) if (!ce_d && !wen_d) mem_d[addr_d[7:0]] <= dqo_d;
    always @(posedge clk) if (!ce_s && !wen_s) mem_s[addr_s[7:0]] <= dqo_s;
    assign dqi_d = (!ce_d && !oen_d) ? mem_d[addr_d[7:0]] : 16'hDEAD;
    assign dqi_s = (!ce_s && !oen_s) ? mem_s[addr_s[7:0]] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string p, input logic [8:0] f, input logic [19:0] a,
                           input logic [15:0] d, input logic [15:0] q);
        chk({p, " rst ce/oe/we/dqoe/rdy/busy/berr/ub/lb"}, {23'd0, f}, 32'b111000000);
        chk({p, " rst addr"}, {12'd0, a}, 32'd0);
        chk({p, " rst dout"}, {16'd0, d}, 32'd0);
        chk({p, " rst dq_out"}, {16'd0, q}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        vec_t tbl [26];
        string fn [7];
        logic [6:0] act_f;
        int oe_low, rdy_n, rdy_at;
        fn = '{"ce_n", "oe_n", "we_n", "dq_oe", "rdy", "busy", "berr"};
        mem_d[8'h40] = 16'h1234;
        mem_s[8'h40] = 16'h1234;
        tbl[0]  = '{2'b01, 20'h40, 16'h0000, 7'b1110000, 20'h00, 16'h0000, 16'h0000};
        tbl[1]  = '{2'b01, 20'h40, 16'h0000, 7'b0010110, 20'h40, 16'h1234, 16'h0000};
        tbl[2]  = '{2'b11, 20'h40, 16'h0000, 7'b1110010, 20'h40, 16'h1234, 16'h0000};
        tbl[3]  = '{2'b11, 20'h40, 16'h0000, 7'b1110000, 20'h40, 16'h1234, 16'h0000};
        tbl[4]  = '{2'b10, 20'h41, 16'hBEEF, 7'b1110000, 20'h40, 16'h1234, 16'h0000};
        tbl[5]  = '{2'b10, 20'h41, 16'hBEEF, 7'b0101010, 20'h41, 16'h1234, 16'hBEEF};
        tbl[6]  = '{2'b11, 20'h41, 16'hBEEF, 7'b0111110, 20'h41, 16'h1234, 16'hBEEF};
        tbl[7]  = '{2'b11, 20'h41, 16'hBEEF, 7'b1110000, 20'h41, 16'h1234, 16'hBEEF};
        tbl[8]  = '{2'b01, 20'h41, 16'hBEEF, 7'b1110000, 20'h41, 16'h1234, 16'hBEEF};
        tbl[9]  = '{2'b01, 20'h41, 16'hBEEF, 7'b0010110, 20'h41, 16'hBEEF, 16'hBEEF};
        tbl[10] = '{2'b11, 20'h41, 16'hBEEF, 7'b1110010, 20'h41, 16'hBEEF, 16'hBEEF};
        tbl[11] = '{2'b11, 20'h41, 16'hBEEF, 7'b1110000, 20'h41, 16'hBEEF, 16'hBEEF};
        tbl[12] = '{2'b01, 20'h40, 16'hBEEF, 7'b1110000, 20'h41, 16'hBEEF, 16'hBEEF};
        tbl[13] = '{2'b01, 20'h40, 16'hBEEF, 7'b0010110, 20'h40, 16'h1234, 16'hBEEF};
        tbl[14] = '{2'b11, 20'h40, 16'hBEEF, 7'b1110010, 20'h40, 16'h1234, 16'hBEEF};
        tbl[15] = '{2'b10, 20'h42, 16'h5A5A, 7'b1110000, 20'h40, 16'h1234, 16'hBEEF};
        tbl[16] = '{2'b10, 20'h42, 16'h5A5A, 7'b0101010, 20'h42, 16'h1234, 16'h5A5A};
        tbl[17] = '{2'b11, 20'h42, 16'h5A5A, 7'b0111110, 20'h42, 16'h1234, 16'h5A5A};
        tbl[18] = '{2'b01, 20'h42, 16'h5A5A, 7'b1110000, 20'h42, 16'h1234, 16'h5A5A};
        tbl[19] = '{2'b01, 20'h42, 16'h5A5A, 7'b0010110, 20'h42, 16'h5A5A, 16'h5A5A};
        tbl[20] = '{2'b11, 20'h42, 16'h5A5A, 7'b1110010, 20'h42, 16'h5A5A, 16'h5A5A};
        tbl[21] = '{2'b11, 20'h42, 16'h5A5A, 7'b1110000, 20'h42, 16'h5A5A, 16'h5A5A};
        tbl[22] = '{2'b00, 20'h43, 16'h0F0F, 7'b1110000, 20'h42, 16'h5A5A, 16'h5A5A};
        tbl[23] = '{2'b00, 20'h43, 16'h0F0F, 7'b0101011, 20'h43, 16'h5A5A, 16'h0F0F};
        tbl[24] = '{2'b11, 20'h43, 16'h0F0F, 7'b0111111, 20'h43, 16'h5A5A, 16'h0F0F};
        tbl[25] = '{2'b11, 20'h43, 16'h0F0F, 7'b1110001, 20'h43, 16'h5A5A, 16'h0F0F};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_rst("def", {ce_d, oen_d, wen_d, dqoe_d, rdy_d, busy_d, berr_d, ub_d, lb_d}, addr_d, dout_d, dqo_d);
        chk_rst("slow", {ce_s, oen_s, wen_s, dqoe_s, rdy_s, busy_s, berr_s, ub_s, lb_s}, addr_s, dout_s, dqo_s);

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            {oe, we} = tbl[i].in;
            mar = tbl[i].mar;
            wd = tbl[i].wd;
            #1;
            act_f = {ce_d, oen_d, wen_d, dqoe_d, rdy_d, busy_d, berr_d};
            for (int b = 0; b < 7; b++)
                chk($sformatf("row%0d %s", i, fn[b]), {31'd0, act_f[6-b]}, {31'd0, tbl[i].flg[6-b]});
            chk($sformatf("row%0d addr", i), {12'd0, addr_d}, {12'd0, tbl[i].addr});
            chk($sformatf("row%0d dout", i), {16'd0, dout_d}, {16'd0, tbl[i].dout});
            chk($sformatf("row%0d dq_out", i), {16'd0, dqo_d}, {16'd0, tbl[i].dqo});
            chk($sformatf("row%0d ub/lb", i), {30'd0, ub_d, lb_d}, 32'd0);
            chk($sformatf("row%0d oe_we_overlap", i), {31'd0, !oen_d && !wen_d}, 32'd0);
        end

        @(negedge clk);
        rst = 1'b1;
        {oe, we} = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_rst("def", {ce_d, oen_d, wen_d, dqoe_d, rdy_d, busy_d, berr_d, ub_d, lb_d}, addr_d, dout_d, dqo_d);
        chk_rst("slow", {ce_s, oen_s, wen_s, dqoe_s, rdy_s, busy_s, berr_s, ub_s, lb_s}, addr_s, dout_s, dqo_s);

        oe_low = 0;
        rdy_n = 0;
        rdy_at = -1;
        mar = 20'h40;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            oe = (i < 6) ? 1'b0 : 1'b1;
            #1;
            if (!oen_s) oe_low++;
            if (rdy_s) begin
                rdy_n++;
                rdy_at = i;
                chk("slow_rd bypass data", {16'd0, dout_s}, 32'h1234);
            end
            if (i == 6) chk("slow_rd busy in recover", {31'd0, busy_s}, 32'd1);
            if (i == 7) chk("slow_rd idle after strobe", {31'd0, busy_s}, 32'd0);
            chk("slow_rd oe_we_overlap", {31'd0, !oen_s && !wen_s}, 32'd0);
        end
        chk("slow_rd oe_n low cycles", oe_low, 32'd3);
        chk("slow_rd ready count", rdy_n, 32'd1);
        chk("slow_rd ready cycle", rdy_at, 32'd3);
        chk("slow_rd held data", {16'd0, dout_s}, 32'h1234);
        chk("slow_rd addr", {12'd0, addr_s}, 32'h40);

        @(negedge clk);
        {oe, we} = 2'b00;
        mar = 20'h44;
        wd = 16'hCAFE;
        @(negedge clk);
        {oe, we} = 2'b11;
        #1;
        chk("slow_wr we_n", {31'd0, wen_s}, 32'd0);
        chk("slow_wr oe_n", {31'd0, oen_s}, 32'd1);
        chk("slow_wr dq_oe", {31'd0, dqoe_s}, 32'd1);
        chk("slow_wr dq_out", {16'd0, dqo_s}, 32'hCAFE);
        chk("slow_wr bus_err", {31'd0, berr_s}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("slow_wr still pulsing", {31'd0, wen_s}, 32'd0);
        chk("slow_wr no ready under reset", {31'd0, rdy_s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("slow_wr rst ce/oe/we", {29'd0, ce_s, oen_s, wen_s}, 32'b111);
        chk("slow_wr rst dq_oe", {31'd0, dqoe_s}, 32'd0);
        chk("slow_wr rst busy", {31'd0, busy_s}, 32'd0);
        chk("slow_wr rst bus_err", {31'd0, berr_s}, 32'd0);
        rdy_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (rdy_s) rdy_n++;
        end
        chk("slow_wr no ready after reset", rdy_n, 32'd0);
        chk("slow_wr stays idle", {31'd0, busy_s}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
